// File: rtl/q9_pkg.sv
// Shared signed Q7.9 fixed-point definitions for the neuron datapath stages.
package q9_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 9;

    localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] Q_MIN = 16'h8000;

    typedef logic signed [Q_W-1:0] q9_t;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        FIN = 2'd1,
        OUT = 2'd2
    } mac_st_t;

endpackage

// File: rtl/q9_round_sat.sv
// Combinational Q.18 (ACC_W bits) to Q7.9 conversion: round half toward +inf,
// then clip to the signed 16-bit range and flag any clipping.
module q9_round_sat
    import q9_pkg::*;
#(
    parameter int ACC_W = 38
) (
    input  logic signed [ACC_W-1:0] sum,
    output q9_t                     value,
    output logic                    sat
);

    localparam int R_MSB = ACC_W - Q_FRAC;

    // floor((s + 2^8) / 2^9) equals the integer part plus the first dropped bit.
    // One extra sign bit keeps the increment from wrapping.
    logic signed [R_MSB:0] rnd;
    logic                  hi_ovf;
    logic                  lo_ovf;
    logic                  unused_frac;

    assign rnd = {sum[ACC_W-1], sum[ACC_W-1:Q_FRAC]}
               + {{(R_MSB){1'b0}}, sum[Q_FRAC-1]};

    // Bits below the rounding bit only affect the result through the floor.
    assign unused_frac = ^sum[Q_FRAC-2:0];

    // Any upper bit that disagrees with the sign means the value left 16 bits.
    assign hi_ovf = ~rnd[R_MSB] &  (|rnd[R_MSB-1:Q_W-1]);
    assign lo_ovf =  rnd[R_MSB] & ~(&rnd[R_MSB-1:Q_W-1]);

    assign sat   = hi_ovf | lo_ovf;
    assign value = hi_ovf ? q9_t'(Q_MAX)
                 : lo_ovf ? q9_t'(Q_MIN)
                 : q9_t'(rnd[Q_W-1:0]);

endmodule

// File: rtl/neuron_mac_q9.sv
// Streaming dot-product for one neuron: accumulates x*w beats, adds the bias,
// and delivers a rounded, saturated Q7.9 pre-activation value.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACC   | accepting beats; product pipelined one cycle, then folded in
//   FIN   | one cycle: final product + bias, round/saturate, clear accum
//   OUT   | result held on out_* until the consumer takes it
module neuron_mac_q9
    import q9_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int ACC_W   = 38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    input  logic        in_last,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic        out_sat,
    output logic        out_trunc
);

    localparam int CNT_W = $clog2(MAX_LEN);

    mac_st_t                  state;
    logic                     armed;
    logic signed [ACC_W-1:0]  acc;
    logic signed [31:0]       prod_r;
    logic                     prod_v;
    logic [CNT_W-1:0]         cnt;
    logic [15:0]              bias_r;
    logic                     trunc_r;

    logic                     accept;
    logic                     cnt_full;
    logic                     end_pkt;
    logic signed [31:0]       mult;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  fin_sum;
    q9_t                      rs_value;
    logic                     rs_sat;

    // armed holds in_ready low for the first cycle after reset releases.
    assign in_ready = armed & (state == ACC);
    assign accept   = in_valid & in_ready;
    assign cnt_full = (cnt == CNT_W'(MAX_LEN - 1));
    assign end_pkt  = accept & (in_last | cnt_full);

    assign mult     = $signed(in_x) * $signed(in_w);
    assign prod_ext = {{(ACC_W-32){prod_r[31]}}, prod_r};
    assign bias_ext = {{(ACC_W-Q_W-Q_FRAC){bias_r[15]}}, bias_r, {Q_FRAC{1'b0}}};
    assign fin_sum  = acc + prod_ext + bias_ext;

    q9_round_sat #(
        .ACC_W (ACC_W)
    ) u_round_sat (
        .sum   (fin_sum),
        .value (rs_value),
        .sat   (rs_sat)
    );

    // Sequencing and accumulation: product of beat n is folded while beat n+1 multiplies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            armed   <= 1'b0;
            acc     <= '0;
            prod_r  <= '0;
            prod_v  <= 1'b0;
            cnt     <= '0;
            bias_r  <= '0;
            trunc_r <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ACC: begin
                    if (accept) begin
                        prod_r <= mult;
                        prod_v <= 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (prod_v) begin
                            acc <= acc + prod_ext;
                        end
                        if (end_pkt) begin
                            state   <= FIN;
                            bias_r  <= bias;
                            trunc_r <= ~in_last;
                        end
                    end else if (prod_v) begin
                        acc    <= acc + prod_ext;
                        prod_v <= 1'b0;
                    end
                end
                FIN: begin
                    acc    <= '0;
                    cnt    <= '0;
                    prod_v <= 1'b0;
                    state  <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // Result registers: loaded in FIN, frozen through OUT, flags dropped on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (state == FIN) begin
            out_valid <= 1'b1;
            out_x     <= rs_value;
            out_sat   <= rs_sat;
            out_trunc <= trunc_r;
        end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_mac_q9.sv
// Directed bench for neuron_mac_q9: table of single/multi-beat packets with
// hand-computed Q7.9 results, plus back-pressure, truncation and reset sequences.
module tb_neuron_mac_q9;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;
    logic        out_trunc;

    int n_cmp = 0;
    int n_err = 0;

    neuron_mac_q9 #(.MAX_LEN(64), .ACC_W(38)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .out_trunc (out_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int          n;
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] ex;
        logic        es;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic send(input logic [15:0] x, input logic [15:0] w,
                        input logic last, input logic [15:0] b);
        int n;
        in_x = x; in_w = w; in_last = last; bias = b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck low, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for out_valid (counting negedges since the call), capture, then hand off.
    task automatic get_result(output logic [15:0] rx, output logic rs, output logic rt,
                              output int lat);
        lat = 0; rx = '0; rs = 1'b0; rt = 1'b0;
        out_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (lat > 100) begin
                n_cmp++; n_err++;
                $display("FAIL result_timeout: out_valid stuck low, expected 1");
                break;
            end
        end
        rx = out_x; rs = out_sat; rt = out_trunc;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [15:0] rx;
    logic        rs, rt;
    int          lat;

    initial begin
        vecs.push_back('{"one",        1, 16'h0200, 16'h0200, 16'h0000, 16'h0200, 1'b0});
        vecs.push_back('{"rnd_up",     1, 16'h0001, 16'h0100, 16'h0000, 16'h0001, 1'b0});
        vecs.push_back('{"rnd_half_n", 1, 16'hFFFF, 16'h0100, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{"rnd_neg",    1, 16'hFFFE, 16'h0100, 16'h0000, 16'hFFFF, 1'b0});
        vecs.push_back('{"bias_neg",   4, 16'h0200, 16'h0080, 16'hFE00, 16'h0000, 1'b0});
        vecs.push_back('{"bias_pos",   4, 16'h0200, 16'h0080, 16'h0100, 16'h0300, 1'b0});
        vecs.push_back('{"neg_acc",    3, 16'h0300, 16'hFE00, 16'h0000, 16'hF700, 1'b0});
        vecs.push_back('{"sat_pos",    4, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1});
        vecs.push_back('{"sat_neg",    4, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 1'b1});
        vecs.push_back('{"edge_max",   1, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0});
        vecs.push_back('{"edge_over",  1, 16'h0001, 16'h0200, 16'h7FFF, 16'h7FFF, 1'b1});
        vecs.push_back('{"edge_min",   1, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0});
        vecs.push_back('{"edge_under", 1, 16'hFFFF, 16'h0200, 16'h8000, 16'h8000, 1'b1});

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0;
        bias = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_high", in_ready, 1);

        // Table-driven packets of identical beats.
        foreach (vecs[i]) begin
            for (int b = 0; b < vecs[i].n; b++)
                send(vecs[i].x, vecs[i].w, (b == vecs[i].n - 1), vecs[i].b);
            get_result(rx, rs, rt, lat);
            chk({vecs[i].name, "_x"}, rx, vecs[i].ex);
            chk({vecs[i].name, "_sat"}, rs, vecs[i].es);
            chk({vecs[i].name, "_trunc"}, rt, 0);
            chk({vecs[i].name, "_lat"}, lat, 2);
            chk({vecs[i].name, "_ready_after"}, in_ready, 1);
        end

        // Back-pressure: result held, offered beat not consumed.
        out_ready = 1'b0;
        send(16'h0200, 16'h0200, 1'b1, 16'h0000);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_valid_seen", out_valid, 1);
        in_x = 16'h0400; in_w = 16'h0200; in_last = 1'b1; bias = 16'h0000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_x", out_x, 16'h0200);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        get_result(rx, rs, rt, lat);
        chk("bp_next_x", rx, 16'h0400);
        chk("bp_next_sat", rs, 0);
        chk("bp_next_lat", lat, 2);

        // Truncation at 64 beats with no in_last; beat 65 starts a fresh packet.
        for (int b = 0; b < 64; b++)
            send(16'h0200, 16'h0200, 1'b0, 16'h0000);
        get_result(rx, rs, rt, lat);
        chk("trunc_x", rx, 16'h7FFF);
        chk("trunc_sat", rs, 1);
        chk("trunc_flag", rt, 1);
        chk("trunc_lat", lat, 2);
        send(16'h0200, 16'h0200, 1'b1, 16'h0000);
        get_result(rx, rs, rt, lat);
        chk("after_trunc_x", rx, 16'h0200);
        chk("after_trunc_sat", rs, 0);
        chk("after_trunc_flag", rt, 0);

        // Reset in the middle of a packet discards the partial sum.
        for (int b = 0; b < 3; b++)
            send(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_x", out_x, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        chk("mid_rst_out_trunc", out_trunc, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(16'h0400, 16'h0200, 1'b1, 16'h0000);
        get_result(rx, rs, rt, lat);
        chk("post_rst_x", rx, 16'h0400);
        chk("post_rst_sat", rs, 0);
        chk("post_rst_trunc", rt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
